// File: rtl/mem_stage_sram.sv
// MIPS memory stage: 32-bit loads/stores against an external 16-bit asynchronous SRAM,
// done as low then high half-word accesses while the rest of the pipeline is stalled.
module mem_stage_sram #(
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned DATA_BASE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_val,
  output logic [31:0] mem_read_value,
  output logic        sram_stall,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {StIdle, StWrLo, StWrHi, StRdLo, StRdHi, StDone} state_e;

  state_e      state_q;
  logic [2:0]  wcnt_q;
  logic [17:0] addr_q;
  logic [15:0] st_hi_q;
  logic [15:0] rd_lo_q;
  logic [15:0] dq_out_q;
  logic [31:0] rd_val_q;
  logic        we_n_q;
  logic        oe_n_q;
  logic        dq_en_q;

  logic [31:0] offset;
  logic [16:0] wa;
  logic        wait_last;
  logic        unused_offset_bits;

  assign offset             = alu_result - DATA_BASE;
  assign wa                 = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign wait_last          = (wcnt_q == 3'(SRAM_WAIT - 1));

  assign sram_addr      = addr_q;
  assign sram_we_n      = we_n_q;
  assign sram_oe_n      = oe_n_q;
  assign sram_dq        = dq_en_q ? dq_out_q : 16'hzzzz;
  assign sram_ce_n      = 1'b0;
  assign sram_ub_n      = 1'b0;
  assign sram_lb_n      = 1'b0;
  assign mem_read_value = rd_val_q;
  assign sram_stall     = (mem_r_en | mem_w_en) & (state_q != StDone);

  // Bus strobes are registered alongside the state so they change exactly on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wcnt_q   <= 3'd0;
      addr_q   <= 18'd0;
      st_hi_q  <= 16'd0;
      rd_lo_q  <= 16'd0;
      dq_out_q <= 16'd0;
      rd_val_q <= 32'd0;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      dq_en_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          wcnt_q <= 3'd0;
          if (mem_w_en) begin
            state_q  <= StWrLo;
            addr_q   <= {wa, 1'b0};
            st_hi_q  <= st_val[31:16];
            dq_out_q <= st_val[15:0];
            dq_en_q  <= 1'b1;
            we_n_q   <= 1'b0;
          end else if (mem_r_en) begin
            state_q <= StRdLo;
            addr_q  <= {wa, 1'b0};
            st_hi_q <= st_val[31:16];
            oe_n_q  <= 1'b0;
          end
        end
        StWrLo: begin
          if (wait_last) begin
            state_q   <= StWrHi;
            wcnt_q    <= 3'd0;
            addr_q[0] <= 1'b1;
            dq_out_q  <= st_hi_q;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        StWrHi: begin
          if (wait_last) begin
            state_q <= StDone;
            wcnt_q  <= 3'd0;
            we_n_q  <= 1'b1;
            dq_en_q <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        StRdLo: begin
          if (wait_last) begin
            state_q   <= StRdHi;
            wcnt_q    <= 3'd0;
            addr_q[0] <= 1'b1;
            rd_lo_q   <= sram_dq;
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        StRdHi: begin
          if (wait_last) begin
            state_q  <= StDone;
            wcnt_q   <= 3'd0;
            oe_n_q   <= 1'b1;
            rd_val_q <= {sram_dq, rd_lo_q};
          end else begin
            wcnt_q <= wcnt_q + 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          wcnt_q  <= 3'd0;
        end
        default: begin
          state_q <= StIdle;
          wcnt_q  <= 3'd0;
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          dq_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Bench for mem_stage_sram: two instances (SRAM_WAIT 1 and 3) each with a 16-bit SRAM model;
// stimulus queues expected bus accesses and completions, a negedge monitor pops and compares.
module tb_mem_stage_sram;

  typedef struct {
    logic        wr;
    logic [17:0] addr;
    logic [15:0] data;
  } bus_t;

  typedef struct {
    logic [31:0] rdv;
    int          stall;
  } txn_t;

  bus_t bus_q[$];
  txn_t txn_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        r_en[2];
  logic        w_en[2];
  logic [31:0] alu[2];
  logic [31:0] stv[2];

  logic [31:0] rdv_a, rdv_b;
  logic        stall_a, stall_b;
  logic [17:0] addr_a, addr_b;
  wire  [15:0] dq_a, dq_b;
  logic        we_a, oe_a, ce_a, ub_a, lb_a;
  logic        we_b, oe_b, ce_b, ub_b, lb_b;

  logic [15:0] mem[2][64];
  logic        loaded = 1'b0;
  logic        prev_act[2];
  logic [17:0] prev_addr[2];
  int          scnt[2];
  int          oe_cnt[2];

  mem_stage_sram #(.SRAM_WAIT(1), .DATA_BASE(1024)) u_w1 (
    .clk(clk), .rst_n(rst_n), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
    .alu_result(alu[0]), .st_val(stv[0]), .mem_read_value(rdv_a), .sram_stall(stall_a),
    .sram_addr(addr_a), .sram_dq(dq_a), .sram_we_n(we_a), .sram_oe_n(oe_a),
    .sram_ce_n(ce_a), .sram_ub_n(ub_a), .sram_lb_n(lb_a)
  );

  mem_stage_sram #(.SRAM_WAIT(3), .DATA_BASE(1024)) u_w3 (
    .clk(clk), .rst_n(rst_n), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
    .alu_result(alu[1]), .st_val(stv[1]), .mem_read_value(rdv_b), .sram_stall(stall_b),
    .sram_addr(addr_b), .sram_dq(dq_b), .sram_we_n(we_b), .sram_oe_n(oe_b),
    .sram_ce_n(ce_b), .sram_ub_n(ub_b), .sram_lb_n(lb_b)
  );

  assign dq_a = (!oe_a && we_a) ? mem[0][addr_a[5:0]] : 16'hzzzz;
  assign dq_b = (!oe_b && we_b) ? mem[1][addr_b[5:0]] : 16'hzzzz;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // An undriven bus reads as Z in 4-state simulators and as 0 in 2-state ones.
  function automatic logic bus_free(logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  task automatic exp_bus(input logic wr, input logic [17:0] a, input logic [15:0] d);
    bus_t e;
    e.wr = wr; e.addr = a; e.data = d;
    bus_q.push_back(e);
  endtask

  task automatic exp_txn(input logic [31:0] rv, input int st);
    txn_t t;
    t.rdv = rv; t.stall = st;
    txn_q.push_back(t);
  endtask

  task automatic mon(input int i, input logic req, input logic st, input logic we_n,
                     input logic oe_n, input logic [17:0] ad, input logic [15:0] d,
                     input logic [31:0] rv);
    logic act;
    bus_t e;
    txn_t t;
    if (!rst_n) begin
      prev_act[i] = 1'b0;
      scnt[i]     = 0;
      return;
    end
    act = !we_n || !oe_n;
    if (!oe_n) oe_cnt[i]++;
    if (!we_n) mem[i][ad[5:0]] = d;
    if (act && (!prev_act[i] || ad != prev_addr[i])) begin
      if (bus_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL bus_unexpected: inst %0d addr 0x%05h we_n %0b at %0t", i, ad, we_n, $time);
      end else begin
        e = bus_q.pop_front();
        chk("bus_dir", 32'(!we_n), 32'(e.wr));
        chk("bus_addr", 32'(ad), 32'(e.addr));
        if (e.wr) chk("bus_wdata", 32'(d), 32'(e.data));
      end
    end
    prev_act[i]  = act;
    prev_addr[i] = ad;
    if (req && st) begin
      scnt[i]++;
    end else if (req) begin
      if (txn_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL txn_unexpected: inst %0d at %0t", i, $time);
      end else begin
        t = txn_q.pop_front();
        chk("mem_read_value", rv, t.rdv);
        chk("stall_cycles", 32'(scnt[i]), 32'(t.stall));
      end
      scnt[i] = 0;
    end else begin
      scnt[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!loaded) begin
      for (int j = 0; j < 64; j++) begin
        mem[0][j] = 16'hA000 + 16'(j);
        mem[1][j] = 16'hB000 + 16'(j);
      end
      mem[1][2] = 16'h1234;
      mem[1][3] = 16'h5678;
      for (int i = 0; i < 2; i++) begin
        prev_act[i] = 1'b0; prev_addr[i] = 18'd0; scnt[i] = 0; oe_cnt[i] = 0;
      end
      loaded = 1'b1;
    end
    mon(0, r_en[0] | w_en[0], stall_a, we_a, oe_a, addr_a, dq_a, rdv_a);
    mon(1, r_en[1] | w_en[1], stall_b, we_b, oe_b, addr_b, dq_b, rdv_b);
  end

  task automatic request(input int i, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] v);
    bit seen = 1'b0;
    @(posedge clk); #1;
    r_en[i] = r; w_en[i] = w; alu[i] = a; stv[i] = v;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (!(i == 1 ? stall_b : stall_a)) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_timeout: inst %0d still stalled after 100 cycles", i);
    end
    @(posedge clk); #1;
    r_en[i] = 1'b0; w_en[i] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe0;
    for (int i = 0; i < 2; i++) begin
      r_en[i] = 1'b0; w_en[i] = 1'b0; alu[i] = 32'd0; stv[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdv_a", rdv_a, 32'd0);
    chk("rst_rdv_b", rdv_b, 32'd0);
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_we_a", 32'(we_a), 32'd1);
    chk("rst_oe_a", 32'(oe_a), 32'd1);
    chk("rst_we_b", 32'(we_b), 32'd1);
    chk("rst_oe_b", 32'(oe_b), 32'd1);
    chk("rst_addr_a", 32'(addr_a), 32'd0);
    chk("rst_dq_free_a", 32'(bus_free(dq_a)), 32'd1);
    chk("ctl_low_a", 32'({ce_a, ub_a, lb_a}), 32'd0);
    chk("ctl_low_b", 32'({ce_b, ub_b, lb_b}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Store then load at the base address
    exp_bus(1'b1, 18'd0, 16'hBEEF); exp_bus(1'b1, 18'd1, 16'hDEAD); exp_txn(32'd0, 3);
    request(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    chk("sram_hw0", 32'(mem[0][0]), 32'h0000BEEF);
    chk("sram_hw1", 32'(mem[0][1]), 32'h0000DEAD);
    exp_bus(1'b0, 18'd0, 16'h0); exp_bus(1'b0, 18'd1, 16'h0); exp_txn(32'hDEADBEEF, 3);
    request(0, 1'b1, 1'b0, 32'd1024, 32'd0);

    // Address mapping; bits [1:0] ignored
    exp_bus(1'b1, 18'd4, 16'h2222); exp_bus(1'b1, 18'd5, 16'h1111); exp_txn(32'hDEADBEEF, 3);
    request(0, 1'b0, 1'b1, 32'd1032, 32'h11112222);
    exp_bus(1'b0, 18'd2, 16'h0); exp_bus(1'b0, 18'd3, 16'h0); exp_txn(32'hA003A002, 3);
    request(0, 1'b1, 1'b0, 32'd1030, 32'd0);

    // Three wait states per half-word
    oe0 = oe_cnt[1];
    exp_bus(1'b0, 18'd2, 16'h0); exp_bus(1'b0, 18'd3, 16'h0); exp_txn(32'h56781234, 7);
    request(1, 1'b1, 1'b0, 32'd1028, 32'd0);
    chk("oe_low_cycles_w3", 32'(oe_cnt[1] - oe0), 32'd6);

    // Read and write together: write wins, load result untouched
    exp_bus(1'b1, 18'd0, 16'hCAFE); exp_bus(1'b1, 18'd1, 16'h0000); exp_txn(32'hA003A002, 3);
    request(0, 1'b1, 1'b1, 32'd1024, 32'h0000CAFE);
    chk("rw_sram_hw0", 32'(mem[0][0]), 32'h0000CAFE);

    // Reset during the high-half write
    exp_bus(1'b1, 18'd0, 16'h6666); exp_bus(1'b1, 18'd1, 16'h5555);
    @(posedge clk); #1;
    w_en[0] = 1'b1; alu[0] = 32'd1024; stv[0] = 32'h55556666;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0; w_en[0] = 1'b0;
    #1;
    chk("midrst_we_a", 32'(we_a), 32'd1);
    chk("midrst_oe_a", 32'(oe_a), 32'd1);
    chk("midrst_dq_free_a", 32'(bus_free(dq_a)), 32'd1);
    chk("midrst_rdv_a", rdv_a, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_bus(1'b0, 18'd0, 16'h0); exp_bus(1'b0, 18'd1, 16'h0); exp_txn(32'h55556666, 3);
    request(0, 1'b1, 1'b0, 32'd1024, 32'd0);

    // No request: transparent
    repeat (10) begin
      @(negedge clk);
      chk("idle_stall", 32'(stall_a), 32'd0);
      chk("idle_we", 32'(we_a), 32'd1);
      chk("idle_oe", 32'(oe_a), 32'd1);
      chk("idle_dq_free", 32'(bus_free(dq_a)), 32'd1);
    end

    chk("bus_q_left", 32'(bus_q.size()), 32'd0);
    chk("txn_q_left", 32'(txn_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
